axi_irq_ctrl: RTL and testbench
===============================

# axi_irq_ctrl

AXI4-Lite interrupt controller placed directly upstream of the PicoRV32 `irq` input. It collects peripheral interrupt lines (timer, UART, future sources) and latches them per source in edge or level mode. It applies a software enable mask and drives the registered, masked vector to the CPU. It consumes the CPU `eoi` vector to retire edge-latched requests.

## Interface
- `AXI_ADDR_BW_p`, 12: AXI address width; only bits [4:2] are decoded.
- `IRQ_NBR_p`, 8: number of interrupt sources, 1..32.
- `clk`  in  1: single clock; all logic is in this domain.
- `rst`  in  1: reset, asynchronous and active-high.
- `i_axi_awaddr`, `i_axi_awvalid`, `o_axi_awready`: write address channel.
- `i_axi_wdata` (32), `i_axi_wvalid`, `o_axi_wready`: write data channel. Full-word writes only; there is no wstrb.
- `o_axi_bresp` (2), `o_axi_bvalid`, `i_axi_bready`: write response channel.
- `i_axi_araddr`, `i_axi_arvalid`, `o_axi_arready`: read address channel.
- `o_axi_rdata` (32), `o_axi_rresp` (2), `o_axi_rvalid`, `i_axi_rready`: read data channel.
- `i_irq_src`  in  IRQ_NBR_p: peripheral interrupt lines, synchronous to `clk`, active-high.
- `i_eoi`  in  IRQ_NBR_p: CPU end-of-interrupt vector; bit high means the CPU is servicing that source.
- `o_irq`  out  IRQ_NBR_p: registered masked request vector to the CPU `irq` input.

## Operation
- Register map (byte offsets):
  - 0x00 PENDING: read returns pending state; write-1-to-clear.
  - 0x04 ENABLE: read/write.
  - 0x08 MODE: read/write; 1 = edge, 0 = level.
  - 0x0C STATUS: read-only; PENDING & ENABLE.
  - 0x10 SWSET: write-only, write-1-to-set PENDING; reads return 0.
- Unmapped offsets return resp SLVERR (2'b10) with rdata 0. Mapped offsets return OKAY. Writes to read-only registers are ignored and still return OKAY.
- Bits at or above `IRQ_NBR_p` read as 0 and ignore writes.
- `src_q` registers `i_irq_src` each cycle for edge detection.
- Edge mode, per bit:
  - Set when `i_irq_src & ~src_q` is high, or when SWSET bit 1 is written.
  - Cleared by a PENDING W1C write, or while the `i_eoi` bit is high.
  - If a set and a clear land in the same cycle, set wins.
- Level mode, per bit: pending = `i_irq_src` OR an SWSET write in that cycle. W1C and `i_eoi` have no effect.
- Switching a bit from edge to level or back does not clear it. The new rule applies from the next edge.
- `o_irq` <= PENDING & ENABLE every cycle.
- Reset values:
  - PENDING, ENABLE, MODE, `src_q` and `o_irq` are 0.
  - `o_axi_awready`, `o_axi_wready`, `o_axi_arready`, `o_axi_bvalid` and `o_axi_rvalid` are 0.
  - `o_axi_bresp`, `o_axi_rresp` and `o_axi_rdata` are 0.
- An asserted reset mid-transaction drops any in-flight response immediately. No response is issued after reset is released.

## Timing
- Write handshake:
  - A write is accepted when awvalid, wvalid and !bvalid are all high. `o_axi_awready` and `o_axi_wready` pulse together for one cycle.
  - The register update and `o_axi_bvalid` both take effect on the next edge.
  - bvalid is held until bready. No new write is accepted while bvalid is high.
  - AW without W, or W without AW, stalls with no ready.
- Read handshake:
  - `o_axi_arready` pulses for one cycle when arvalid is high and rvalid is low.
  - `o_axi_rvalid` and `o_axi_rdata` are registered on the next edge and held stable until rready.
- Read/write ordering:
  - Read and write may be accepted in the same cycle.
  - A read accepted in the same cycle as a write to the same register returns the pre-write value.
- Interrupt latency:
  - A source rising edge sampled at edge k makes PENDING = 1 after edge k and `o_irq` = 1 after edge k+1.
  - The same two-cycle latency applies to SWSET, measured from write acceptance, and to a W1C clear propagating to `o_irq`.
- Edge mode uses a one-cycle pulse on `i_irq_src`, which must be detected. A source held high produces exactly one set.

## Structure
- `picorv32_soc_pkg` receives:
  - Register offset constants: `IRQC_PENDING_OFFS_p`, `IRQC_ENABLE_OFFS_p`, `IRQC_MODE_OFFS_p`, `IRQC_STATUS_OFFS_p`, `IRQC_SWSET_OFFS_p`.
  - `IRQ_NBR_p`.
  - The existing RESP_OKAY and RESP_SLVERR values.
- One sub-module, `axi_irq_ctrl_source`, holds the per-bit edge detector, pending flop and set/clear priority. It is instantiated `IRQ_NBR_p` times in a generate loop.
- The AXI front end and register decode stay in the top module.

## Test plan
- Reset, then read all five offsets -> all return 0 with OKAY. Read 0x14 -> rdata 0, resp 2'b10.
- ENABLE = 0x03, MODE = 0x01, one-cycle pulse on `i_irq_src[0]` -> PENDING = 0x01 one cycle later and `o_irq` = 0x01 a cycle after that. Write PENDING = 0x01 -> `o_irq` = 0 two cycles after acceptance.
- MODE = 0, ENABLE = 0x02, hold `i_irq_src[1]` high for 5 cycles -> `o_irq[1]` high for exactly 5 cycles, delayed 2. A W1C write during the pulse has no effect.
- Edge mode: a source rising edge coincides with an `i_eoi` clear of the same bit -> the bit stays pending. SWSET = 0x80 with ENABLE = 0 -> PENDING = 0x80, STATUS = 0, `o_irq` = 0.
- Back-to-back writes with bready held low for 4 cycles -> awready/wready stay low until B completes. The second write lands exactly once.
- Assert `rst` while rvalid is pending -> all outputs go to 0 asynchronously, and no stale rvalid appears after release.

Source files
------------

// File: rtl/picorv32_soc_pkg.sv
// -----------------------------------------------------------------------------
// picorv32_soc_pkg
// Shared constants for the PicoRV32 SoC slice: AXI response codes, the
// interrupt-controller register map and the default number of interrupt
// sources.
// -----------------------------------------------------------------------------
package picorv32_soc_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Number of interrupt sources wired to the CPU
    localparam int IRQ_NBR_p = 8;

    // Interrupt controller register byte offsets (only [4:2] are decoded)
    localparam logic [4:0] IRQC_PENDING_OFFS_p = 5'h00;
    localparam logic [4:0] IRQC_ENABLE_OFFS_p  = 5'h04;
    localparam logic [4:0] IRQC_MODE_OFFS_p    = 5'h08;
    localparam logic [4:0] IRQC_STATUS_OFFS_p  = 5'h0C;
    localparam logic [4:0] IRQC_SWSET_OFFS_p   = 5'h10;

endpackage

// File: rtl/axi_irq_ctrl_source.sv
// -----------------------------------------------------------------------------
// axi_irq_ctrl_source
// One interrupt source: input edge detector, pending flop and the set/clear
// priority for edge and level mode.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   src        : peripheral interrupt line (synchronous, active-high)
//   edge_mode  : 1 = edge-latched, 0 = level-following
//   sw_set     : software set pulse (SWSET write accepted this cycle)
//   w1c        : software clear pulse (PENDING W1C write accepted this cycle)
//   eoi        : CPU end-of-interrupt for this source
//   pending    : registered pending state
// -----------------------------------------------------------------------------
module axi_irq_ctrl_source (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic sw_set,
    input  logic w1c,
    input  logic eoi,
    output logic pending
);

    logic src_q;
    logic rise;
    logic pending_d;

    always_comb begin
        rise      = src & ~src_q;
        pending_d = pending;
        if (edge_mode) begin
            // A new request beats a simultaneous clear so no edge is lost.
            if (rise || sw_set) begin
                pending_d = 1'b1;
            end else if (w1c || eoi) begin
                pending_d = 1'b0;
            end
        end else begin
            // Level mode follows the line; W1C and eoi are irrelevant here.
            pending_d = src | sw_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            src_q   <= src;
            pending <= pending_d;
        end
    end

endmodule

// File: rtl/axi_irq_ctrl.sv
// -----------------------------------------------------------------------------
// axi_irq_ctrl
// AXI4-Lite interrupt controller feeding the PicoRV32 irq input. Latches each
// source in edge or level mode, masks with ENABLE and drives a registered
// request vector. CPU eoi retires edge-latched requests.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   i_axi_aw*/w*/b*       : AXI4-Lite write channels (full-word, no wstrb)
//   i_axi_ar*/r*          : AXI4-Lite read channels
//   i_irq_src [IRQ_NBR_p] : peripheral interrupt lines
//   i_eoi     [IRQ_NBR_p] : CPU end-of-interrupt vector
//   o_irq     [IRQ_NBR_p] : registered PENDING & ENABLE to the CPU
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Writes are accepted when awvalid, wvalid and !bvalid are high;
// awready/wready are high only in that cycle and the register update plus
// bvalid land on the same edge. bvalid then holds until bready. Reads are
// accepted (arready high) when arvalid is high and rvalid is low; rdata and
// rresp are captured from the pre-update register state and held with rvalid
// until rready. Readies are forced low during reset.
// -----------------------------------------------------------------------------
module axi_irq_ctrl #(
    parameter int AXI_ADDR_BW_p = 12,
    parameter int IRQ_NBR_p     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
    input  logic                     i_axi_awvalid,
    output logic                     o_axi_awready,
    input  logic [31:0]              i_axi_wdata,
    input  logic                     i_axi_wvalid,
    output logic                     o_axi_wready,
    output logic [1:0]               o_axi_bresp,
    output logic                     o_axi_bvalid,
    input  logic                     i_axi_bready,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
    input  logic                     i_axi_arvalid,
    output logic                     o_axi_arready,
    output logic [31:0]              o_axi_rdata,
    output logic [1:0]               o_axi_rresp,
    output logic                     o_axi_rvalid,
    input  logic                     i_axi_rready,
    input  logic [IRQ_NBR_p-1:0]     i_irq_src,
    input  logic [IRQ_NBR_p-1:0]     i_eoi,
    output logic [IRQ_NBR_p-1:0]     o_irq
);

    import picorv32_soc_pkg::*;

    localparam logic [2:0] PEND_IDX   = IRQC_PENDING_OFFS_p[4:2];
    localparam logic [2:0] ENABLE_IDX = IRQC_ENABLE_OFFS_p[4:2];
    localparam logic [2:0] MODE_IDX   = IRQC_MODE_OFFS_p[4:2];
    localparam logic [2:0] STATUS_IDX = IRQC_STATUS_OFFS_p[4:2];
    localparam logic [2:0] SWSET_IDX  = IRQC_SWSET_OFFS_p[4:2];

    logic                 wr_acc;
    logic                 rd_acc;
    logic [2:0]           wr_idx;
    logic [2:0]           rd_idx;
    logic                 wr_mapped;
    logic [IRQ_NBR_p-1:0] wdata_n;
    logic [IRQ_NBR_p-1:0] enable_q;
    logic [IRQ_NBR_p-1:0] mode_q;
    logic [IRQ_NBR_p-1:0] pending;
    logic [IRQ_NBR_p-1:0] sw_set;
    logic [IRQ_NBR_p-1:0] w1c;
    logic [31:0]          rd_word;
    logic [1:0]           rd_resp;
    logic                 unused_bits;

    // Upper address bits and data bits above IRQ_NBR_p are ignored by design.
    assign unused_bits = ^{i_axi_awaddr, i_axi_araddr, i_axi_wdata};

    assign wr_acc = i_axi_awvalid & i_axi_wvalid & ~o_axi_bvalid & ~rst;
    assign rd_acc = i_axi_arvalid & ~o_axi_rvalid & ~rst;

    assign o_axi_awready = wr_acc;
    assign o_axi_wready  = wr_acc;
    assign o_axi_arready = rd_acc;

    assign wr_idx  = i_axi_awaddr[4:2];
    assign rd_idx  = i_axi_araddr[4:2];
    assign wdata_n = i_axi_wdata[IRQ_NBR_p-1:0];

    assign wr_mapped = (wr_idx == PEND_IDX)   || (wr_idx == ENABLE_IDX) ||
                       (wr_idx == MODE_IDX)   || (wr_idx == STATUS_IDX) ||
                       (wr_idx == SWSET_IDX);

    // Single-cycle set/clear strobes to the per-source logic.
    always_comb begin
        sw_set = '0;
        w1c    = '0;
        if (wr_acc && (wr_idx == SWSET_IDX)) sw_set = wdata_n;
        if (wr_acc && (wr_idx == PEND_IDX))  w1c    = wdata_n;
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        if (rd_idx == PEND_IDX) begin
            rd_word = 32'(pending);
        end else if (rd_idx == ENABLE_IDX) begin
            rd_word = 32'(enable_q);
        end else if (rd_idx == MODE_IDX) begin
            rd_word = 32'(mode_q);
        end else if (rd_idx == STATUS_IDX) begin
            rd_word = 32'(pending & enable_q);
        end else if (rd_idx == SWSET_IDX) begin
            rd_word = '0;
        end else begin
            rd_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q     <= '0;
            mode_q       <= '0;
            o_axi_bvalid <= 1'b0;
            o_axi_bresp  <= RESP_OKAY;
            o_axi_rvalid <= 1'b0;
            o_axi_rresp  <= RESP_OKAY;
            o_axi_rdata  <= '0;
            o_irq        <= '0;
        end else begin
            if (wr_acc) begin
                if (wr_idx == ENABLE_IDX) enable_q <= wdata_n;
                if (wr_idx == MODE_IDX)   mode_q   <= wdata_n;
                o_axi_bvalid <= 1'b1;
                o_axi_bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (o_axi_bvalid && i_axi_bready) begin
                o_axi_bvalid <= 1'b0;
            end

            if (rd_acc) begin
                o_axi_rvalid <= 1'b1;
                o_axi_rdata  <= rd_word;
                o_axi_rresp  <= rd_resp;
            end else if (o_axi_rvalid && i_axi_rready) begin
                o_axi_rvalid <= 1'b0;
            end

            o_irq <= pending & enable_q;
        end
    end

    for (genvar g = 0; g < IRQ_NBR_p; g++) begin : g_src
        axi_irq_ctrl_source u_src (
            .clk       (clk),
            .rst       (rst),
            .src       (i_irq_src[g]),
            .edge_mode (mode_q[g]),
            .sw_set    (sw_set[g]),
            .w1c       (w1c[g]),
            .eoi       (i_eoi[g]),
            .pending   (pending[g])
        );
    end

endmodule

// File: tb/tb_axi_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_irq_ctrl
// Directed scenarios plus randomized AXI/interrupt traffic against a
// cycle-level behavioural model of the interrupt controller.
// -----------------------------------------------------------------------------
module tb_axi_irq_ctrl;

    localparam int N  = 8;
    localparam int AW = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [N-1:0]  irq_src;
    logic [N-1:0]  eoi;
    logic [N-1:0]  irq;

    axi_irq_ctrl #(.AXI_ADDR_BW_p(AW), .IRQ_NBR_p(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_axi_awaddr  (awaddr),
        .i_axi_awvalid (awvalid),
        .o_axi_awready (awready),
        .i_axi_wdata   (wdata),
        .i_axi_wvalid  (wvalid),
        .o_axi_wready  (wready),
        .o_axi_bresp   (bresp),
        .o_axi_bvalid  (bvalid),
        .i_axi_bready  (bready),
        .i_axi_araddr  (araddr),
        .i_axi_arvalid (arvalid),
        .o_axi_arready (arready),
        .o_axi_rdata   (rdata),
        .o_axi_rresp   (rresp),
        .o_axi_rvalid  (rvalid),
        .i_axi_rready  (rready),
        .i_irq_src     (irq_src),
        .i_eoi         (eoi),
        .o_irq         (irq)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Register state as the software would see it, plus outstanding responses.
    bit [N-1:0] m_pend   = '0;
    bit [N-1:0] m_en     = '0;
    bit [N-1:0] m_mode   = '0;
    bit [N-1:0] m_prev   = '0;
    bit [N-1:0] m_irq    = '0;
    bit         m_bvalid = 1'b0;
    bit [1:0]   m_bresp  = 2'b00;
    bit         m_rvalid = 1'b0;
    logic [33:0] exp_q[$];

    function automatic bit [31:0] reg_value(input int idx);
        case (idx)
            0:       return 32'(m_pend);
            1:       return 32'(m_en);
            2:       return 32'(m_mode);
            3:       return 32'(m_pend & m_en);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit [1:0] reg_resp(input int idx);
        return (idx <= 4) ? 2'b00 : 2'b10;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit         wacc, racc, sw, clr, rise, b, r;
        int         widx, ridx;
        bit [N-1:0] nxt_pend, nxt_en, nxt_mode;
        if (rst) begin
            m_pend   <= '0;
            m_en     <= '0;
            m_mode   <= '0;
            m_prev   <= '0;
            m_irq    <= '0;
            m_bvalid <= 1'b0;
            m_bresp  <= 2'b00;
            m_rvalid <= 1'b0;
            exp_q.delete();
        end else begin
            wacc = awvalid && wvalid && !m_bvalid;
            racc = arvalid && !m_rvalid;
            widx = int'(awaddr[4:2]);
            ridx = int'(araddr[4:2]);

            r = m_rvalid;
            if (m_rvalid && rready) r = 1'b0;
            if (racc) begin
                r = 1'b1;
                exp_q.push_back({reg_resp(ridx), reg_value(ridx)});
            end

            for (int i = 0; i < N; i++) begin
                sw   = wacc && (widx == 4) && wdata[i];
                clr  = (wacc && (widx == 0) && wdata[i]) || eoi[i];
                rise = irq_src[i] && !m_prev[i];
                if (m_mode[i]) nxt_pend[i] = (rise || sw) ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
                else           nxt_pend[i] = irq_src[i] || sw;
            end

            nxt_en   = (wacc && widx == 1) ? wdata[N-1:0] : m_en;
            nxt_mode = (wacc && widx == 2) ? wdata[N-1:0] : m_mode;

            b = m_bvalid;
            if (m_bvalid && bready) b = 1'b0;
            if (wacc) begin
                b = 1'b1;
                m_bresp <= reg_resp(widx);
            end

            m_irq    <= m_pend & m_en;
            m_pend   <= nxt_pend;
            m_en     <= nxt_en;
            m_mode   <= nxt_mode;
            m_bvalid <= b;
            m_rvalid <= r;
            m_prev   <= irq_src;
        end
    end

    // Every cycle, away from the active edge: outputs against the model.
    always @(negedge clk) begin
        logic [33:0] e;
        #2;
        check("o_irq", 32'(irq), 32'(m_irq));
        check("bvalid", 32'(bvalid), 32'(m_bvalid));
        if (m_bvalid) check("bresp", 32'(bresp), 32'(m_bresp));
        check("rvalid", 32'(rvalid), 32'(m_rvalid));
        check("awready", 32'(awready), 32'(!rst && awvalid && wvalid && !m_bvalid));
        check("wready", 32'(wready), 32'(!rst && awvalid && wvalid && !m_bvalid));
        check("arready", 32'(arready), 32'(!rst && arvalid && !m_rvalid));
        if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
                check("r_unexpected", 32'(rvalid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("rdata", rdata, e[31:0]);
                check("rresp", 32'(rresp), 32'(e[33:32]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        #3;
        n = 0;
        while (!awready && n < 50) begin
            @(negedge clk); #3; n++;
        end
        check("aw_wait", 32'(n < 50), 32'(1));
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        #3;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clk); #3; n++;
        end
        check("ar_wait", 32'(n < 50), 32'(1));
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("r_wait", 32'(n < 50), 32'(1));
        d = rdata;
        r = rresp;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a      = AW'($urandom);
        a[4:2] = 3'($urandom_range(0, 7));
        a[1:0] = 2'b00;
        return a;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        n_err++;
        $display("FAIL watchdog: got=timeout exp=finish t=%0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          cnt, first, acc;
        bit          aw_acc, ar_acc;

        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1; irq_src = '0; eoi = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_irq", 32'(irq), 32'(0));
        check("rst_bvalid", 32'(bvalid), 32'(0));
        check("rst_rvalid", 32'(rvalid), 32'(0));
        check("rst_rdata", rdata, 32'h0);

        // All mapped offsets read 0/OKAY out of reset; 0x14 is unmapped.
        for (int i = 0; i < 5; i++) begin
            axi_read(AW'(i * 4), d, r);
            check("rd_rst_data", d, 32'h0);
            check("rd_rst_resp", 32'(r), 32'(0));
        end
        axi_read(12'h014, d, r);
        check("rd_unmapped_data", d, 32'h0);
        check("rd_unmapped_resp", 32'(r), 32'(2));

        // Edge mode: one-cycle pulse on source 0.
        axi_write(12'h004, 32'h03);
        axi_write(12'h008, 32'h01);
        @(negedge clk); irq_src[0] = 1'b1;
        @(negedge clk); irq_src[0] = 1'b0;
        #2 check("edge_irq_k", 32'(irq), 32'h00);
        @(negedge clk);
        #2 check("edge_irq_k1", 32'(irq), 32'h01);
        axi_read(12'h000, d, r);
        check("edge_pending", d, 32'h01);
        axi_write(12'h000, 32'h01);
        check("w1c_irq_hold", 32'(irq), 32'h01);
        @(posedge clk); #1;
        check("w1c_irq_clr", 32'(irq), 32'h00);

        // Level mode: source 1 held 5 cycles, W1C in the middle is ignored.
        axi_write(12'h008, 32'h00);
        axi_write(12'h004, 32'h02);
        cnt = 0; first = -1;
        fork
            begin
                @(negedge clk); irq_src[1] = 1'b1;
                repeat (5) @(negedge clk);
                irq_src[1] = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                axi_write(12'h000, 32'h02);
            end
            begin
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk); #2;
                    if (irq[1]) begin
                        cnt++;
                        if (first < 0) first = i;
                    end
                end
            end
        join
        check("lvl_cnt", 32'(cnt), 32'd5);
        check("lvl_first", 32'(first), 32'd2);

        // Edge mode: rising edge coincides with eoi for the same bit.
        axi_write(12'h008, 32'hFF);
        @(negedge clk); irq_src[2] = 1'b1; eoi[2] = 1'b1;
        @(negedge clk); irq_src[2] = 1'b0; eoi[2] = 1'b0;
        axi_read(12'h000, d, r);
        check("eoi_race_pend", d, 32'h04);
        @(negedge clk); eoi[2] = 1'b1;
        @(negedge clk); eoi[2] = 1'b0;
        axi_read(12'h000, d, r);
        check("eoi_clear", d, 32'h00);

        // SWSET with everything masked.
        axi_write(12'h004, 32'h00);
        axi_write(12'h010, 32'h80);
        axi_write(12'h00C, 32'hFF);
        axi_read(12'h000, d, r);
        check("swset_pend", d, 32'h80);
        axi_read(12'h00C, d, r);
        check("swset_status", d, 32'h00);
        check("swset_irq", 32'(irq), 32'h00);
        axi_read(12'h010, d, r);
        check("swset_rd0", d, 32'h00);
        axi_write(12'h000, 32'hFF);

        // Back-to-back writes with bready held low.
        bready = 1'b0;
        acc = 0;
        fork
            begin
                axi_write(12'h004, 32'h11);
                axi_write(12'h004, 32'h22);
            end
            begin
                repeat (5) @(negedge clk);
                bready = 1'b1;
            end
            begin
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk); #3;
                    if (awready) acc++;
                end
            end
        join
        check("b2b_accepts", 32'(acc), 32'd2);
        axi_read(12'h004, d, r);
        check("b2b_enable", d, 32'h22);

        // Randomized traffic.
        aw_acc = 1'b0; ar_acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (aw_acc) begin awvalid = 1'b0; wvalid = 1'b0; end
            if (ar_acc) arvalid = 1'b0;
            if (!awvalid && $urandom_range(0, 3) == 0) begin awvalid = 1'b1; awaddr = rand_addr(); end
            if (!wvalid && $urandom_range(0, 3) == 0) begin wvalid = 1'b1; wdata = $urandom; end
            if (!arvalid && $urandom_range(0, 2) == 0) begin arvalid = 1'b1; araddr = rand_addr(); end
            bready  = ($urandom_range(0, 3) != 0);
            rready  = ($urandom_range(0, 3) != 0);
            irq_src = irq_src ^ N'($urandom & $urandom & $urandom);
            eoi     = N'($urandom & $urandom & $urandom & $urandom);
            #3;
            aw_acc = awready;
            ar_acc = arready;
        end
        @(negedge clk);
        if (aw_acc) begin awvalid = 1'b0; wvalid = 1'b0; end
        if (ar_acc) arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1; irq_src = '0; eoi = '0;
        repeat (60) @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        // Reset while a read response is outstanding.
        axi_write(12'h008, 32'hFF);
        axi_write(12'h004, 32'hFF);
        axi_write(12'h010, 32'h01);
        rready = 1'b0;
        @(negedge clk);
        araddr = 12'h004; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("pre_rst_rvalid", 32'(rvalid), 32'(1));
        check("pre_rst_rdata", rdata, 32'hFF);
        check("pre_rst_irq", 32'(irq[0]), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_rvalid", 32'(rvalid), 32'(0));
        check("arst_rdata", rdata, 32'h0);
        check("arst_rresp", 32'(rresp), 32'(0));
        check("arst_bvalid", 32'(bvalid), 32'(0));
        check("arst_bresp", 32'(bresp), 32'(0));
        check("arst_irq", 32'(irq), 32'(0));
        check("arst_ready", 32'({awready, wready, arready}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            check("post_rst_rvalid", 32'(rvalid), 32'(0));
        end
        axi_read(12'h004, d, r);
        check("post_rst_enable", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
